// File: rtl/loop_iterator.sv
// Bounded multi-pass index generator: sweeps start_value toward limit_value by step,
// repeats the sweep pass_count times, then pulses done.
module loop_iterator #(
  parameter int COUNTER_WIDTH = 6,
  parameter int PASS_WIDTH    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     clock_enable,
  input  logic                     direction,
  input  logic [COUNTER_WIDTH-1:0] start_value,
  input  logic [COUNTER_WIDTH-1:0] limit_value,
  input  logic [COUNTER_WIDTH-1:0] step,
  input  logic [PASS_WIDTH-1:0]    pass_count,
  output logic [COUNTER_WIDTH-1:0] iterator,
  output logic                     busy,
  output logic                     last,
  output logic                     wrapped,
  output logic                     done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state;
  logic                     cfg_dir;
  logic [COUNTER_WIDTH-1:0] cfg_start;
  logic [COUNTER_WIDTH-1:0] cfg_limit;
  logic [COUNTER_WIDTH-1:0] cfg_step;
  logic [PASS_WIDTH-1:0]    pass_left;
  logic [COUNTER_WIDTH:0]   ext_iter;
  logic [COUNTER_WIDTH:0]   ext_step;
  logic [COUNTER_WIDTH:0]   ext_limit;
  logic                     terminal;

  // One extra bit so the bound test sees the true sum/difference, never a wrapped one.
  always_comb begin
    ext_iter  = {1'b0, iterator};
    ext_step  = {1'b0, cfg_step};
    ext_limit = {1'b0, cfg_limit};
    if (cfg_dir)
      terminal = ext_iter < (ext_step + ext_limit);
    else
      terminal = (ext_iter + ext_step) > ext_limit;
  end

  assign last = busy & terminal;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      iterator  <= '0;
      busy      <= 1'b0;
      wrapped   <= 1'b0;
      done      <= 1'b0;
      pass_left <= '0;
      cfg_dir   <= 1'b0;
      cfg_start <= '0;
      cfg_limit <= '0;
      cfg_step  <= '0;
    end else begin
      wrapped <= 1'b0;
      done    <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        iterator  <= '0;
        busy      <= 1'b0;
        pass_left <= '0;
        cfg_dir   <= 1'b0;
        cfg_start <= '0;
        cfg_limit <= '0;
        cfg_step  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              cfg_dir   <= direction;
              cfg_start <= start_value;
              cfg_limit <= limit_value;
              cfg_step  <= (step == '0) ? COUNTER_WIDTH'(1) : step;
              iterator  <= start_value;
              pass_left <= pass_count;
              busy      <= 1'b1;
              state     <= RUN;
            end
          end
          RUN: begin
            if (clock_enable) begin
              if (!terminal) begin
                iterator <= cfg_dir ? (iterator - cfg_step) : (iterator + cfg_step);
              end else if (pass_left == PASS_WIDTH'(1)) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                // A zero pass counter means free-running: it is never decremented.
                iterator <= cfg_start;
                wrapped  <= 1'b1;
                if (pass_left != '0)
                  pass_left <= pass_left - PASS_WIDTH'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_loop_iterator.sv
// Bench for loop_iterator: element-list model checked every cycle, plus directed literal checks.
module tb_loop_iterator;
  localparam int W = 6;
  localparam int P = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic         clock_enable = 1'b0;
  logic         direction = 1'b0;
  logic [W-1:0] start_value = '0;
  logic [W-1:0] limit_value = '0;
  logic [W-1:0] step = '0;
  logic [P-1:0] pass_count = '0;
  logic [W-1:0] iterator;
  logic         busy, last, wrapped, done;

  int checks = 0;
  int failures = 0;

  loop_iterator #(.COUNTER_WIDTH(W), .PASS_WIDTH(P)) dut (
    .clock(clock), .reset(reset), .clear(clear), .start(start),
    .clock_enable(clock_enable), .direction(direction),
    .start_value(start_value), .limit_value(limit_value), .step(step),
    .pass_count(pass_count), .iterator(iterator), .busy(busy),
    .last(last), .wrapped(wrapped), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each pass is a precomputed list of elements; position k walks it.
  bit m_run, m_wr, m_dn, m_free;
  int m_iter, k, passes_left;
  int elems[$];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_wr = 0; m_dn = 0; m_iter = 0; k = 0; passes_left = 0; m_free = 0;
      elems.delete();
    end else begin
      m_wr = 0;
      m_dn = 0;
      if (clear) begin
        m_run = 0; m_iter = 0; k = 0; passes_left = 0; m_free = 0;
        elems.delete();
      end else if (!m_run) begin
        if (start) begin
          int s, e, nx;
          s = (step == 0) ? 1 : int'(step);
          e = int'(start_value);
          elems.delete();
          for (int n = 0; n < 200; n++) begin
            elems.push_back(e);
            nx = direction ? e - s : e + s;
            if (direction ? (nx < int'(limit_value)) : (nx > int'(limit_value))) break;
            e = nx;
          end
          k = 0;
          m_iter = elems[0];
          passes_left = int'(pass_count);
          m_free = (pass_count == 0);
          m_run = 1;
        end
      end else if (clock_enable) begin
        if (k < elems.size() - 1) begin
          k++;
          m_iter = elems[k];
        end else if (!m_free && passes_left == 1) begin
          m_run = 0;
          m_dn = 1;
        end else begin
          k = 0;
          m_iter = elems[0];
          m_wr = 1;
          if (!m_free) passes_left--;
        end
      end
    end
  end

  always @(posedge clock) begin
    #2;
    if (reset) begin
      chk("iterator", int'(iterator), m_iter);
      chk("busy", int'(busy), int'(m_run));
      chk("last", int'(last), int'(m_run && k == elems.size() - 1));
      chk("wrapped", int'(wrapped), int'(m_wr));
      chk("done", int'(done), int'(m_dn));
    end
  end

  task automatic tick(input bit en);
    clock_enable = en;
    @(negedge clock);
  endtask

  task automatic do_start(input bit d, input int s, input int l, input int st, input int p);
    direction   = d;
    start_value = W'(s);
    limit_value = W'(l);
    step        = W'(st);
    pass_count  = P'(p);
    clock_enable = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    int s1[6];
    int s2[6];
    s1 = '{0, 1, 2, 3, 4, 5};
    s2 = '{9, 6, 3, 9, 6, 3};

    #1;
    chk("rst_iterator", int'(iterator), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wrapped", int'(wrapped), 0);
    @(negedge clock);
    reset = 1'b1;
    tick(0);
    tick(0);

    // Basic up count
    do_start(0, 0, 5, 1, 1);
    for (int i = 0; i < 6; i++) begin
      chk("up_iter", int'(iterator), s1[i]);
      chk("up_last", int'(last), int'(i == 5));
      tick(1);
    end
    chk("up_done", int'(done), 1);
    chk("up_busy_low", int'(busy), 0);
    chk("up_hold", int'(iterator), 5);
    tick(0);
    chk("up_done_pulse", int'(done), 0);
    chk("up_idle_hold", int'(iterator), 5);

    // Down, step 3, two passes
    do_start(1, 9, 2, 3, 2);
    for (int i = 0; i < 6; i++) begin
      chk("down_iter", int'(iterator), s2[i]);
      chk("down_last", int'(last), int'(i == 2 || i == 5));
      chk("down_wrapped", int'(wrapped), int'(i == 3));
      tick(1);
    end
    chk("down_done", int'(done), 1);
    tick(0);

    // Width boundary
    do_start(0, 60, 63, 2, 1);
    chk("wb_first", int'(iterator), 60);
    tick(1);
    chk("wb_second", int'(iterator), 62);
    chk("wb_last", int'(last), 1);
    tick(1);
    chk("wb_done", int'(done), 1);
    chk("wb_hold", int'(iterator), 62);
    tick(0);

    // Gated enable, step 0 acts as 1
    do_start(0, 0, 5, 0, 1);
    chk("gate_0", int'(iterator), 0);
    tick(1);
    chk("gate_1", int'(iterator), 1);
    tick(0);
    chk("gate_hold_a", int'(iterator), 1);
    tick(0);
    chk("gate_hold_b", int'(iterator), 1);
    tick(1);
    chk("gate_2", int'(iterator), 2);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;

    // Degenerate start beyond the bound, then back-to-back start in the done cycle
    do_start(0, 7, 3, 1, 1);
    chk("degen_iter", int'(iterator), 7);
    chk("degen_last", int'(last), 1);
    tick(1);
    chk("degen_done", int'(done), 1);
    chk("degen_hold", int'(iterator), 7);
    do_start(1, 9, 2, 3, 1);
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_iter", int'(iterator), 9);

    // Start during RUN is ignored
    start = 1'b1;
    start_value = W'(20);
    direction = 1'b0;
    tick(1);
    start = 1'b0;
    chk("midstart_iter", int'(iterator), 6);
    tick(1);
    chk("midstart_last", int'(last), 1);
    tick(1);
    chk("midstart_done", int'(done), 1);
    tick(0);

    // Free-running with pass_count 0, then clear
    do_start(0, 0, 1, 1, 0);
    repeat (9) tick(1);
    chk("free_iter", int'(iterator), 1);
    chk("free_busy", int'(busy), 1);
    clock_enable = 1'b1;
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clear_iter", int'(iterator), 0);
    chk("clear_busy", int'(busy), 0);

    // Clear beats start
    clear = 1'b1;
    start = 1'b1;
    start_value = W'(5);
    @(negedge clock);
    clear = 1'b0;
    start = 1'b0;
    chk("clrstart_busy", int'(busy), 0);
    chk("clrstart_iter", int'(iterator), 0);
    tick(0);

    // Asynchronous reset mid-run
    do_start(0, 10, 20, 2, 3);
    tick(1);
    tick(1);
    chk("ar_pre", int'(iterator), 14);
    #2 reset = 1'b0;
    #1;
    chk("ar_iter", int'(iterator), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_last", int'(last), 0);
    #1 reset = 1'b1;
    @(negedge clock);
    tick(1);
    tick(1);
    tick(1);
    chk("ar_idle_busy", int'(busy), 0);
    chk("ar_idle_iter", int'(iterator), 0);
    clock_enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/loop_iterator.md
# loop_iterator

Parametrised loop-index generator for the activation unit. It replaces the free-running `up_counter` wherever a bounded, multi-pass index sequence is needed, such as walking activation buffer addresses or feature-map rows. After a start pulse it emits `start_value`, `start_value ± step`, … up to `limit_value`, repeats that sweep `pass_count` times, then signals completion. It provides up/down direction, programmable step, a terminal-element flag and wrap/done pulses.

## Interface
- `COUNTER_WIDTH`, default 6: width of the index, bounds and step.
- `PASS_WIDTH`, default 4: width of the pass (repeat) counter.

- `clock`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `clear`, input, 1: synchronous abort. Returns the block to IDLE and has priority over all other inputs.
- `start`, input, 1: single-cycle pulse. Latches the configuration and begins a run. Honoured only in IDLE.
- `clock_enable`, input, 1: advance strobe. Only RUN cycles with `clock_enable`=1 step the index.
- `direction`, input, 1: 0 counts up, 1 counts down. Latched at start.
- `start_value`, input, COUNTER_WIDTH: first index of every pass. Latched at start.
- `limit_value`, input, COUNTER_WIDTH: inclusive bound (upper bound when counting up, lower bound when counting down). Latched at start.
- `step`, input, COUNTER_WIDTH: increment magnitude. Latched at start. A value of 0 is treated as 1.
- `pass_count`, input, PASS_WIDTH: number of sweeps. Latched at start. A value of 0 means free-running until `clear`.
- `iterator`, output, COUNTER_WIDTH: current index, registered.
- `busy`, output, 1: high in RUN, registered.
- `last`, output, 1: high when `iterator` is the final element of the current pass (busy & terminal condition). Combinational from registers only.
- `wrapped`, output, 1: one-cycle pulse, registered, marking the first element of each pass after the first.
- `done`, output, 1: one-cycle pulse, registered, marking run completion.

## Operation
- States: IDLE and RUN. `done` is a registered pulse, not a separate state.
- Reset (`reset`=0, asynchronous): state IDLE; `iterator`=0, `busy`=0, `wrapped`=0, `done`=0, pass counter=0, latched configuration=0.
- `clear`=1: the next edge gives the same values as reset. It wins over `start` and `clock_enable` in the same cycle.
- IDLE with `start`=1:
  - Latch the configuration.
  - Set `iterator` to `start_value`.
  - Load the pass counter with `pass_count`.
  - Enter RUN.
- `start` while in RUN is ignored.
- Terminal condition, evaluated at COUNTER_WIDTH+1 bits with no overflow:
  - Up: `iterator` + step > `limit_value`, or the sum exceeds 2^COUNTER_WIDTH−1.
  - Down: `iterator` < step + `limit_value`, i.e. `iterator` − step would be below the limit or negative.
- RUN, `clock_enable`=1, not terminal: `iterator` ← `iterator` ± step (exact result, never wraps modulo 2^W).
- RUN, `clock_enable`=1, terminal:
  - If the pass counter is 1: go to IDLE, `busy`←0, `done`←1, and `iterator` holds its final value.
  - Otherwise: `iterator` ← latched `start_value`, `wrapped`←1, and the pass counter decrements. When `pass_count` was 0 the counter is not decremented, so the run never ends.
- RUN, `clock_enable`=0: all state frozen; pulses deassert.
- Degenerate start beyond the bound (up: `start_value` > `limit_value`; down: `start_value` < `limit_value`):
  - Each pass is exactly one element, `start_value`.
  - `last`=1 throughout.
- The index is never outside [min(start,limit), max(start,limit)], except in the degenerate case above.
- In IDLE, `iterator` holds its last value until the next start, clear or reset.

## Timing
- `start` at edge n: `busy`=1 and `iterator`=`start_value` after edge n. The first index is visible the cycle after `start`.
- Each `clock_enable` edge in RUN produces the next index after that edge (latency 1).
- `last` is valid in the same cycle as the terminal `iterator` value.
- `wrapped` is high during the cycle `iterator` first shows the restarted `start_value`.
- `done` is high for exactly one cycle, after the final advance edge. `busy`=0 in that same cycle.
- A new `start` is accepted in the `done` cycle, giving back-to-back runs with no dead cycle.
- A single run of P passes with E elements per pass takes E·P enable edges.

## Test plan
- **Basic up count.** start=0, limit=5, step=1, pass=1, dir=up, `clock_enable` held 1.
  - Required: `iterator` 0,1,2,3,4,5.
  - `last` high on 5.
  - `done` one cycle after, `busy` low, `iterator` stays 5.
- **Down with step and repeat.** start=9, limit=2, step=3, pass=2, dir=down.
  - Required: 9,6,3,9,6,3.
  - `last` high on both 3s.
  - `wrapped` high on the second 9.
  - `done` after the second 3.
- **Width boundary.** W=6, start=60, limit=63, step=2, up.
  - Required: 60,62, then terminate. Never 0/64.
- **Gated and degenerate.** Toggle `clock_enable` 1,0,0,1: `iterator` holds during the 0 cycles.
  - start=7, limit=3, up: single element 7, `last`=1, `done` after one enable.
  - step=0 behaves as step=1.
- **Control priority.**
  - `start` mid-RUN: ignored.
  - pass=0: wraps indefinitely, no `done`; `clear` gives IDLE, `iterator`=0 next edge.
  - `clear`+`start` in the same cycle: IDLE.
  - Back-to-back `start` in the `done` cycle: accepted.
- **Asynchronous reset mid-run.** Assert `reset`=0 between edges.
  - Required: outputs 0 immediately, without waiting for a clock edge.
  - After release: stays IDLE until `start`.
